// File: rtl/fixed_mac_pkg.sv
// fixed_mac_pkg: fixed-point widths, FSM states and saturation constants.
// Build option FIXED_MAC_ROUND_EN: round half-up instead of floor on fraction cut.
package fixed_mac_pkg;

    localparam int WI1   = 6;
    localparam int WF1   = 10;
    localparam int WI2   = 4;
    localparam int WF2   = 8;
    localparam int WIO   = 7;
    localparam int WFO   = 13;
    localparam int EXTRA = 5;

    localparam int A_W    = WI1 + WF1;
    localparam int B_W    = WI2 + WF2;
    localparam int PROD_I = WI1 + WI2;
    localparam int PROD_F = WF1 + WF2;
    localparam int PROD_W = PROD_I + PROD_F;
    localparam int ACC_I  = PROD_I + EXTRA;
    localparam int ACC_W  = ACC_I + PROD_F;
    localparam int OUT_W  = WIO + WFO;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN_A = 2'd1,
        ST_DRAIN_B = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] sat_max();
        return {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    function automatic logic [OUT_W-1:0] sat_min();
        return {1'b1, {(OUT_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/fixed_mac_resize.sv
// fixed_mac_resize: accumulator -> WIO.WFO conversion with range check.
// FIXED_MAC_ROUND_EN selects round half-up for the dropped fraction bits.
module fixed_mac_resize
    import fixed_mac_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic                    i_of_sat,
    input  logic                    i_uf_sat,
    output logic [OUT_W-1:0]        o_data,
    output logic                    o_overflow,
    output logic                    o_underflow
);

    // One guard bit above the accumulator integer part absorbs the rounding carry.
    localparam int TRIM_W = ACC_I + 1 + WFO;

    logic signed [TRIM_W-1:0] w_trim;
    logic [TRIM_W-OUT_W:0]    w_hi;
    logic                     w_ovf;
    logic                     w_unf;

    generate
        if (WFO > PROD_F) begin : g_pad
            assign w_trim = {i_acc[ACC_W-1], i_acc, {(WFO-PROD_F){1'b0}}};
        end else if (WFO == PROD_F) begin : g_same
            assign w_trim = {i_acc[ACC_W-1], i_acc};
        end else begin : g_cut
            localparam int DROP = PROD_F - WFO;
            logic w_unused_lsb;
`ifdef FIXED_MAC_ROUND_EN
            localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (DROP-1);
            logic [ACC_W:0] w_rnd;
            assign w_rnd        = {i_acc[ACC_W-1], i_acc} + HALF;
            assign w_trim       = w_rnd[ACC_W:DROP];
            assign w_unused_lsb = ^w_rnd[DROP-1:0];
`else
            assign w_trim       = {i_acc[ACC_W-1], i_acc[ACC_W-1:DROP]};
            assign w_unused_lsb = ^i_acc[DROP-1:0];
`endif
        end
    endgenerate

    // In range iff every bit from the output sign upward matches.
    assign w_hi  = w_trim[TRIM_W-1:OUT_W-1];
    assign w_ovf = ~w_trim[TRIM_W-1] & (|w_hi);
    assign w_unf = w_trim[TRIM_W-1] & ~(&w_hi);

    always_comb begin
        o_data = w_trim[OUT_W-1:0];
        if (w_ovf && i_of_sat) begin
            o_data = sat_max();
        end else if (w_unf && i_uf_sat) begin
            o_data = sat_min();
        end
    end

    assign o_overflow  = w_ovf;
    assign o_underflow = w_unf;

endmodule

// File: rtl/fixed_mac.sv
// fixed_mac: streaming signed fixed-point MAC over paired A/B packets.
// Build option FIXED_MAC_ROUND_EN: rounded output fraction (see fixed_mac_resize).
module fixed_mac
    import fixed_mac_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [A_W-1:0]   A_data,
    input  logic             A_valid,
    input  logic             A_last,
    output logic             A_ready,
    input  logic [B_W-1:0]   B_data,
    input  logic             B_valid,
    input  logic             B_last,
    output logic             B_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             OF_saturation,
    output logic             underflow,
    input  logic             UF_saturation
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [OUT_W-1:0]         r_out_data;
    logic                     r_out_valid;
    logic                     r_overflow;
    logic                     r_underflow;

    logic                     w_stall;
    logic                     w_fire;
    logic                     w_end;
    logic [PROD_W-1:0]        w_a_ext;
    logic [PROD_W-1:0]        w_b_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic [OUT_W-1:0]         w_res;
    logic                     w_res_ovf;
    logic                     w_res_unf;

    assign w_stall = r_out_valid & ~out_ready;

    assign A_ready = ((r_state == ST_RUN) & ~w_stall) | (r_state == ST_DRAIN_A);
    assign B_ready = ((r_state == ST_RUN) & ~w_stall) | (r_state == ST_DRAIN_B);

    assign w_fire = (r_state == ST_RUN) & A_valid & B_valid & ~w_stall;
    assign w_end  = w_fire & (A_last | B_last);

    // Low PROD_W bits of the sign-extended product equal the signed product.
    assign w_a_ext = {{B_W{A_data[A_W-1]}}, A_data};
    assign w_b_ext = {{A_W{B_data[B_W-1]}}, B_data};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_sum   = r_acc + {{EXTRA{w_prod[PROD_W-1]}}, w_prod};

    fixed_mac_resize u_resize (
        .i_acc       (w_sum),
        .i_of_sat    (OF_saturation),
        .i_uf_sat    (UF_saturation),
        .o_data      (w_res),
        .o_overflow  (w_res_ovf),
        .o_underflow (w_res_unf)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_end && B_last && !A_last) begin
                    w_state_nxt = ST_DRAIN_A;
                end else if (w_end && A_last && !B_last) begin
                    w_state_nxt = ST_DRAIN_B;
                end
            end
            ST_DRAIN_A: begin
                if (A_valid && A_last) w_state_nxt = ST_RUN;
            end
            ST_DRAIN_B: begin
                if (B_valid && B_last) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_acc <= w_end ? '0 : w_sum;
            end
            if (w_end) begin
                r_out_data  <= w_res;
                r_overflow  <= w_res_ovf;
                r_underflow <= w_res_unf;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fixed_mac.sv
// tb_fixed_mac: directed vectors plus a small reference model for fixed_mac.
// Inputs change on the falling edge; outputs are read away from the rising edge.
module tb_fixed_mac;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] A_data = '0;
    logic        A_valid = 1'b0;
    logic        A_last = 1'b0;
    logic        A_ready;
    logic [11:0] B_data = '0;
    logic        B_valid = 1'b0;
    logic        B_last = 1'b0;
    logic        B_ready;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overflow;
    logic        OF_saturation = 1'b1;
    logic        underflow;
    logic        UF_saturation = 1'b1;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_res = 0;
    logic [19:0] res_data = '0;
    logic        res_ov = 1'b0;
    logic        res_uf = 1'b0;

    fixed_mac dut (
        .clk           (clk),
        .reset         (reset),
        .A_data        (A_data),
        .A_valid       (A_valid),
        .A_last        (A_last),
        .A_ready       (A_ready),
        .B_data        (B_data),
        .B_valid       (B_valid),
        .B_last        (B_last),
        .B_ready       (B_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overflow      (overflow),
        .OF_saturation (OF_saturation),
        .underflow     (underflow),
        .UF_saturation (UF_saturation)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            n_res++;
            res_data = out_data;
            res_ov   = overflow;
            res_uf   = underflow;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] model(input longint acc, input bit ofs,
                                          input bit ufs);
        longint      t;
        bit          ov;
        bit          uf;
        logic [19:0] d;
`ifdef FIXED_MAC_ROUND_EN
        t = (acc + 16) >>> 5;
`else
        t = acc >>> 5;
`endif
        ov = t > 64'sd524287;
        uf = t < -64'sd524288;
        d  = t[19:0];
        if (ov && ofs) d = 20'h7FFFF;
        else if (uf && ufs) d = 20'h80000;
        return {ov, uf, d};
    endfunction

    // Called on a falling edge; both sides present a beat until it fires.
    task automatic send(input int n, input logic [15:0] a,
                        input logic [11:0] b, input bit fin);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            A_data  = a;
            B_data  = b;
            A_valid = 1'b1;
            B_valid = 1'b1;
            A_last  = fin && (i == n - 1);
            B_last  = A_last;
            #1;
            while (!(A_ready && B_ready) && t < 200) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 200) check("send_timeout", t, 0);
            @(negedge clk);
        end
        A_valid = 1'b0;
        B_valid = 1'b0;
        A_last  = 1'b0;
        B_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [19:0] d,
                              input bit ov, input bit uf);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_ovf"}, overflow, ov);
        check({tag, "_unf"}, underflow, uf);
    endtask

    logic [15:0] ra[13];
    logic [11:0] rb[12];
    longint      acc_m;
    logic [21:0] exp_m;
    int          base;
    bit          held;

    initial begin
        // reset state
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_a_ready", A_ready, 1);
        check("idle_b_ready", B_ready, 1);

        // 1.0 * 1.0, one beat, one clock latency
        send(1, 16'h0400, 12'h100, 1);
        expect_out("t1", 20'h02000, 0, 0);
        @(negedge clk);
        check("t1_drop", out_valid, 0);

        send(4, 16'h0400, 12'h100, 1);
        expect_out("t2", 20'h08000, 0, 0);

        send(30, 16'h7FFF, 12'h7FF, 1);
        expect_out("t3_sat", 20'h7FFFF, 1, 0);
        OF_saturation = 1'b0;
        send(30, 16'h7FFF, 12'h7FF, 1);
`ifdef FIXED_MAC_ROUND_EN
        expect_out("t3_wrap", 20'hF8081, 1, 0);
`else
        expect_out("t3_wrap", 20'hF8080, 1, 0);
`endif
        OF_saturation = 1'b1;

        send(30, 16'h8000, 12'h7FF, 1);
        expect_out("t4_sat", 20'h80000, 0, 1);

        // -1.0 * 1.5 = -1.5
        send(1, 16'hFC00, 12'h180, 1);
        expect_out("neg", 20'hFD000, 0, 0);
        send(1, 16'hFFFF, 12'h001, 1);
`ifdef FIXED_MAC_ROUND_EN
        expect_out("floor_neg", 20'h00000, 0, 0);
`else
        expect_out("floor_neg", 20'hFFFFF, 0, 0);
`endif
        send(1, 16'h0003, 12'h00B, 1);
        expect_out("floor_pos", 20'h00001, 0, 0);

        // backpressure
        @(negedge clk);
        out_ready = 1'b0;
        send(1, 16'h0400, 12'h100, 1);
        expect_out("t5", 20'h02000, 0, 0);
        held = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            held &= out_valid && (out_data == 20'h02000) && !A_ready && !B_ready;
        end
        check("t5_hold", held, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_released", out_valid, 0);
        check("t5_a_ready", A_ready, 1);
        check("t5_b_ready", B_ready, 1);

        // B_last one beat ahead of A_last; trailing A beat is drained
        acc_m = 0;
        for (int i = 0; i < 12; i++) begin
            ra[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
            rb[i] = 12'($urandom);
            acc_m += longint'($signed(ra[i])) * longint'($signed(rb[i]));
        end
        ra[12] = 16'h1234;
        exp_m  = model(acc_m, OF_saturation, UF_saturation);
        base   = n_res;
        fork
            begin
                for (int i = 0; i < 13; i++) begin
                    int t = 0;
                    if (i % 7 == 6) begin
                        A_valid = 1'b0;
                        @(negedge clk);
                    end
                    A_data  = ra[i];
                    A_last  = (i == 12);
                    A_valid = 1'b1;
                    #1;
                    while (!(A_ready && (B_valid || !B_ready)) && t < 200) begin
                        @(negedge clk);
                        #1;
                        t++;
                    end
                    if (t >= 200) check("a_timeout", t, 0);
                    @(negedge clk);
                end
                A_valid = 1'b0;
                A_last  = 1'b0;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    int t = 0;
                    if (i % 9 == 8) begin
                        B_valid = 1'b0;
                        @(negedge clk);
                    end
                    B_data  = rb[i];
                    B_last  = (i == 11);
                    B_valid = 1'b1;
                    #1;
                    while (!(B_ready && (A_valid || !A_ready)) && t < 200) begin
                        @(negedge clk);
                        #1;
                        t++;
                    end
                    if (t >= 200) check("b_timeout", t, 0);
                    @(negedge clk);
                end
                B_valid = 1'b0;
                B_last  = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("t6_count", n_res - base, 1);
        check("t6_data", res_data, exp_m[19:0]);
        check("t6_ovf", res_ov, exp_m[21]);
        check("t6_unf", res_uf, exp_m[20]);
        check("t6_run_a", A_ready, 1);
        check("t6_run_b", B_ready, 1);
        send(1, 16'h0400, 12'h100, 1);
        expect_out("t6_next", 20'h02000, 0, 0);

        // reset mid-packet drops the partial sum
        @(negedge clk);
        send(3, 16'h0400, 12'h100, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        send(1, 16'h0400, 12'h100, 1);
        expect_out("mid_rst", 20'h02000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
